// File: rtl/adc_emulator_pkg.sv
// rtl/adc_emulator_pkg.sv - shared types and constants for the ADC emulator
package adc_emulator_pkg;

    localparam int DATA_W = 13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } adc_state_t;

    typedef enum logic [1:0] {
        PAT_RAMP  = 2'd0,
        PAT_CONST = 2'd1,
        PAT_ALT   = 2'd2,
        PAT_WALK  = 2'd3
    } pattern_t;

    typedef enum logic [1:0] {
        ADJ_NONE = 2'd0,
        ADJ_INC  = 2'd1,
        ADJ_DEC  = 2'd2
    } adj_t;

    localparam logic [DATA_W-1:0] ALT_SEED_A = 13'h0AAA;
    localparam logic [DATA_W-1:0] ALT_SEED_B = 13'h1555;
    localparam logic [DATA_W-1:0] WALK_SEED  = 13'h0001;
    localparam logic [3:0]        PERIOD_MIN = 4'd3;

    function automatic logic [3:0] clamp_period(input logic [3:0] p);
        return (p < PERIOD_MIN) ? PERIOD_MIN : p;
    endfunction

endpackage

// File: rtl/adc_emulator_if.sv
// rtl/adc_emulator_if.sv - control and data bundle of the ADC emulator
interface adc_emulator_if;
    import adc_emulator_pkg::*;

    logic              en;
    logic [3:0]        period;
    logic [1:0]        pattern_sel;
    logic [DATA_W-1:0] const_val;
    logic              phase_ce;
    logic              phase_inc;
    logic              drdy;
    logic [DATA_W-1:0] data_out;
    logic              phase_busy;
    logic [6:0]        phase_pos;
    logic              saturated;

    modport master (
        output en, period, pattern_sel, const_val, phase_ce, phase_inc,
        input  drdy, data_out, phase_busy, phase_pos, saturated
    );

    modport slave (
        input  en, period, pattern_sel, const_val, phase_ce, phase_inc,
        output drdy, data_out, phase_busy, phase_pos, saturated
    );
endinterface

// File: rtl/adc_pattern_gen.sv
// rtl/adc_pattern_gen.sv - test-pattern word source, stepped once per data-ready
module adc_pattern_gen
    import adc_emulator_pkg::*;
(
    input  logic              clk357,
    input  logic              rst,
    input  logic              advance,
    input  logic              restart,
    input  logic [1:0]        pattern_sel,
    input  logic [DATA_W-1:0] const_val,
    output logic [DATA_W-1:0] word
);
    logic [DATA_W-1:0] ramp_q, walk_q;
    logic              alt_q;
    logic [DATA_W-1:0] ramp_cur, walk_cur;
    logic              alt_cur;

    // restart presents the seed word in the same cycle it is consumed
    always_comb begin
        ramp_cur = restart ? '0 : ramp_q;
        walk_cur = restart ? WALK_SEED : walk_q;
        alt_cur  = restart ? 1'b0 : alt_q;
        word     = '0;
        case (pattern_t'(pattern_sel))
            PAT_RAMP:  word = ramp_cur;
            PAT_CONST: word = const_val;
            PAT_ALT:   word = alt_cur ? ALT_SEED_B : ALT_SEED_A;
            default:   word = walk_cur;
        endcase
    end

    always_ff @(posedge clk357 or posedge rst) begin
        if (rst) begin
            ramp_q <= '0;
            walk_q <= WALK_SEED;
            alt_q  <= 1'b0;
        end else if (advance) begin
            ramp_q <= ramp_cur + 1'b1;
            walk_q <= {walk_cur[DATA_W-2:0], walk_cur[DATA_W-1]};
            alt_q  <= ~alt_cur;
        end else if (restart) begin
            ramp_q <= '0;
            walk_q <= WALK_SEED;
            alt_q  <= 1'b0;
        end
    end
endmodule

// File: rtl/adc_emulator.sv
// rtl/adc_emulator.sv - ADC data-ready/word emulator with tap-step phase adjustment
module adc_emulator
    import adc_emulator_pkg::*;
#(
    parameter int MAX_PHASE = 63
) (
    input  logic          clk357,
    input  logic          rst,
    adc_emulator_if.slave bus
);
    localparam logic [6:0] MAX_POS = 7'(MAX_PHASE);

    adc_state_t        state_q, state_d;
    logic [6:0]        cnt_q, cnt_d;
    logic [3:0]        per_q, per_d;
    adj_t              adj_cur_q, adj_cur_d;
    adj_t              adj_next_q, adj_next_d;
    logic              busy_q, busy_d;
    logic              drdy_q, drdy_d;
    logic [DATA_W-1:0] data_q, word;
    logic [6:0]        pos_q;
    logic              sat_q;
    logic [4:0]        target;
    logic [6:0]        last_cnt, near_cnt;
    logic              period_end, step_req, at_limit, step_ok;
    logic              advance, restart;
    adj_t              step_adj;

    // effective length of the running period including any pending tap step
    always_comb begin
        target = {1'b0, per_q};
        if (adj_cur_q == ADJ_INC) begin
            target = target + 5'd1;
        end else if (adj_cur_q == ADJ_DEC) begin
            target = target - 5'd1;
        end
        last_cnt   = {2'b00, target - 5'd1};
        near_cnt   = {2'b00, target - 5'd2};
        period_end = (cnt_q == last_cnt);
        step_req   = bus.phase_ce && !busy_q;
        at_limit   = bus.phase_inc ? (pos_q == MAX_POS) : (pos_q == 7'd0);
        step_ok    = step_req && !at_limit;
        step_adj   = bus.phase_inc ? ADJ_INC : ADJ_DEC;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        per_d      = per_q;
        adj_cur_d  = adj_cur_q;
        adj_next_d = adj_next_q;
        busy_d     = busy_q;
        drdy_d     = 1'b0;
        advance    = 1'b0;
        restart    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.en) begin
                    state_d = ST_SYNC;
                    cnt_d   = '0;
                end
            end
            ST_SYNC: begin
                if (!bus.en) begin
                    state_d = ST_IDLE;
                end else if (cnt_q > pos_q) begin
                    state_d    = ST_RUN;
                    cnt_d      = '0;
                    drdy_d     = 1'b1;
                    per_d      = clamp_period(bus.period);
                    adj_cur_d  = ADJ_NONE;
                    adj_next_d = ADJ_NONE;
                    advance    = 1'b1;
                    restart    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            ST_RUN: begin
                if (!bus.en) begin
                    state_d    = ST_IDLE;
                    adj_cur_d  = ADJ_NONE;
                    adj_next_d = ADJ_NONE;
                    busy_d     = 1'b0;
                end else begin
                    // busy drops one cycle after the drdy that closed the adjusted period
                    if (busy_q && drdy_q && adj_cur_q == ADJ_NONE && adj_next_q == ADJ_NONE) begin
                        busy_d = 1'b0;
                    end
                    if (period_end) begin
                        drdy_d     = 1'b1;
                        cnt_d      = '0;
                        per_d      = clamp_period(bus.period);
                        adj_cur_d  = adj_next_q;
                        adj_next_d = ADJ_NONE;
                        advance    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                    if (step_ok) begin
                        busy_d = 1'b1;
                        if (period_end) begin
                            adj_cur_d = step_adj;
                        end else if (!bus.phase_inc && cnt_q == near_cnt) begin
                            adj_next_d = ADJ_DEC;
                        end else begin
                            adj_cur_d = step_adj;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk357 or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk357 or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            per_q      <= PERIOD_MIN;
            adj_cur_q  <= ADJ_NONE;
            adj_next_q <= ADJ_NONE;
            busy_q     <= 1'b0;
            drdy_q     <= 1'b0;
            data_q     <= '0;
            pos_q      <= '0;
            sat_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            per_q      <= per_d;
            adj_cur_q  <= adj_cur_d;
            adj_next_q <= adj_next_d;
            busy_q     <= busy_d;
            drdy_q     <= drdy_d;
            if (drdy_d) begin
                data_q <= word;
            end
            if (step_ok) begin
                pos_q <= bus.phase_inc ? pos_q + 7'd1 : pos_q - 7'd1;
            end
            if (step_req && at_limit) begin
                sat_q <= 1'b1;
            end
        end
    end

    adc_pattern_gen u_pattern (
        .clk357      (clk357),
        .rst         (rst),
        .advance     (advance),
        .restart     (restart),
        .pattern_sel (bus.pattern_sel),
        .const_val   (bus.const_val),
        .word        (word)
    );

    assign bus.drdy       = drdy_q;
    assign bus.data_out   = data_q;
    assign bus.phase_busy = busy_q;
    assign bus.phase_pos  = pos_q;
    assign bus.saturated  = sat_q;
endmodule

// File: tb/tb_adc_emulator.sv
// tb/tb_adc_emulator.sv - randomized self-checking bench for adc_emulator
module tb_adc_emulator;
    logic clk357 = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    int   hold_err = 0;
    int   model_pos = 0;

    adc_emulator_if bus();

    adc_emulator #(.MAX_PHASE(63)) dut (
        .clk357 (clk357),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk357 = ~clk357;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk357);
        #1;
    endtask

    function automatic logic [12:0] exp_word(input int sel, input int k, input logic [12:0] cv);
        case (sel)
            0:       return 13'(k % 8192);
            1:       return cv;
            2:       return (k % 2 == 0) ? 13'h0AAA : 13'h1555;
            default: return 13'(1 << (k % 13));
        endcase
    endfunction

    function automatic int eff_period(input int p);
        return (p < 3) ? 3 : p;
    endfunction

    task automatic wait_drdy(output int gap);
        logic [12:0] d0;
        d0  = bus.data_out;
        gap = 0;
        do begin
            tick();
            gap++;
            if (!bus.drdy && bus.data_out !== d0) hold_err++;
        end while (!bus.drdy && gap < 200);
        if (!bus.drdy) check_eq("drdy_timeout", bus.drdy, 1);
    endtask

    task automatic start_run(input int p, input int sel, input logic [12:0] cv);
        int n;
        bus.period      = 4'(p);
        bus.pattern_sel = 2'(sel);
        bus.const_val   = cv;
        bus.en          = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.drdy && n < 200);
        check_eq("first_gap", n, model_pos + 3);
        check_eq("first_word", bus.data_out, exp_word(sel, 0, cv));
    endtask

    task automatic go_idle();
        bus.en = 1'b0;
        tick();
        check_eq("idle_drdy", bus.drdy, 0);
        tick();
    endtask

    task automatic reset_outputs(input string tag);
        check_eq({tag, "_drdy"}, bus.drdy, 0);
        check_eq({tag, "_data"}, bus.data_out, 0);
        check_eq({tag, "_busy"}, bus.phase_busy, 0);
        check_eq({tag, "_pos"}, bus.phase_pos, 0);
        check_eq({tag, "_sat"}, bus.saturated, 0);
    endtask

    initial begin
        int g, n, errs, p, sel;
        logic [12:0] cv, ew;

        rst = 1'b1;
        bus.en = 1'b0;
        bus.period = 4'd0;
        bus.pattern_sel = 2'd0;
        bus.const_val = '0;
        bus.phase_ce = 1'b0;
        bus.phase_inc = 1'b0;
        repeat (3) tick();
        reset_outputs("reset");
        rst = 1'b0;
        tick();

        // basic ramp at P=5
        start_run(5, 0, 13'h0);
        tick();
        check_eq("drdy_width", bus.drdy, 0);
        wait_drdy(g);
        check_eq("ramp_gap1", g, 4);
        check_eq("ramp_word1", bus.data_out, 13'h0001);
        wait_drdy(g);
        check_eq("ramp_gap2", g, 5);
        check_eq("ramp_word2", bus.data_out, 13'h0002);

        // random period / pattern runs
        for (int t = 0; t < 6; t++) begin
            go_idle();
            p   = $urandom_range(0, 15);
            sel = $urandom_range(0, 3);
            cv  = 13'($urandom);
            start_run(p, sel, cv);
            for (int k = 1; k <= 4; k++) begin
                wait_drdy(g);
                check_eq("rand_gap", g, eff_period(p));
                check_eq("rand_word", bus.data_out, exp_word(sel, k, cv));
            end
        end

        // period change mid-period, and clamped period
        go_idle();
        start_run(4, 0, 13'h0);
        bus.period = 4'd6;
        wait_drdy(g);
        check_eq("pchg_gap_cur", g, 4);
        wait_drdy(g);
        check_eq("pchg_gap_next", g, 6);
        go_idle();
        start_run(1, 0, 13'h0);
        wait_drdy(g);
        check_eq("pmin_gap1", g, 3);
        wait_drdy(g);
        check_eq("pmin_gap2", g, 3);

        // random phase steps while running at P=8
        go_idle();
        start_run(8, 0, 13'h0);
        for (int t = 0; t < 12; t++) begin
            int d, r, s, ai, j, last, nd;
            int gexp[3];
            bit busy_chk;
            s = (model_pos == 0) ? 1 : (($urandom_range(0, 1) == 1) ? 1 : -1);
            d = $urandom_range(0, 7);
            r = 8 - (d + 1);
            if (r == 0) begin
                gexp = '{8, 8 + s, 8}; ai = 2;
            end else if (s < 0 && r == 1) begin
                gexp = '{8, 7, 8}; ai = 2;
            end else begin
                gexp = '{8 + s, 8, 8}; ai = 1;
            end
            j = 0; last = 0; nd = 0; busy_chk = 1'b0;
            while (nd < 3 && j < 60) begin
                if (j == d) begin
                    bus.phase_ce = 1'b1;
                    bus.phase_inc = (s > 0);
                end
                tick();
                j++;
                if (j == d + 1) begin
                    bus.phase_ce = 1'b0;
                    model_pos += s;
                    check_eq("step_pos", bus.phase_pos, model_pos);
                    check_eq("step_busy", bus.phase_busy, 1);
                end
                if (busy_chk) begin
                    check_eq("busy_release", bus.phase_busy, 0);
                    busy_chk = 1'b0;
                end
                if (bus.drdy) begin
                    check_eq("step_gap", j - last, gexp[nd]);
                    last = j;
                    nd++;
                    if (nd == ai) begin
                        check_eq("busy_at_drdy", bus.phase_busy, 1);
                        busy_chk = 1'b1;
                    end
                end
            end
            if (nd < 3) check_eq("step_drdy_count", nd, 3);
        end

        // unwind position in IDLE, then saturate at zero while running
        go_idle();
        check_eq("sat_clear", bus.saturated, 0);
        while (model_pos > 0) begin
            bus.phase_ce = 1'b1;
            bus.phase_inc = 1'b0;
            tick();
            model_pos--;
            check_eq("idle_pos", bus.phase_pos, model_pos);
            check_eq("idle_busy", bus.phase_busy, 0);
        end
        bus.phase_ce = 1'b0;
        start_run(6, 1, 13'h0F0F);
        tick();
        tick();
        bus.phase_ce = 1'b1;
        bus.phase_inc = 1'b0;
        tick();
        bus.phase_ce = 1'b0;
        check_eq("sat_pos", bus.phase_pos, 0);
        check_eq("sat_set", bus.saturated, 1);
        check_eq("sat_busy", bus.phase_busy, 0);
        wait_drdy(g);
        check_eq("sat_gap1", g + 3, 6);
        wait_drdy(g);
        check_eq("sat_gap2", g, 6);

        // climb to the top limit in IDLE, then SYNC uses the full offset
        go_idle();
        bus.phase_ce = 1'b1;
        bus.phase_inc = 1'b1;
        repeat (63) tick();
        bus.phase_ce = 1'b0;
        model_pos = 63;
        check_eq("max_pos", bus.phase_pos, 63);
        bus.phase_ce = 1'b1;
        tick();
        bus.phase_ce = 1'b0;
        check_eq("max_hold", bus.phase_pos, 63);
        check_eq("max_busy", bus.phase_busy, 0);
        start_run(4, 3, 13'h0);
        for (int k = 1; k <= 13; k++) begin
            wait_drdy(g);
            check_eq("walk_word", bus.data_out, exp_word(3, k, 13'h0));
        end

        // ramp wraparound, then pattern change at next drdy
        go_idle();
        start_run(3, 0, 13'h0);
        errs = 0;
        for (int k = 1; k <= 8193; k++) begin
            wait_drdy(g);
            ew = exp_word(0, k, 13'h0);
            if (g != 3 || bus.data_out !== ew) errs++;
            if (k >= 8190) check_eq("ramp_wrap", bus.data_out, ew);
        end
        check_eq("ramp_errs", errs, 0);
        bus.pattern_sel = 2'd1;
        bus.const_val = 13'h1234;
        wait_drdy(g);
        check_eq("sel_change", bus.data_out, 13'h1234);

        // alternating pattern
        go_idle();
        start_run(5, 2, 13'h0);
        wait_drdy(g);
        check_eq("alt_word1", bus.data_out, 13'h1555);
        wait_drdy(g);
        check_eq("alt_word2", bus.data_out, 13'h0AAA);

        // asynchronous reset during a pending step, en held high
        go_idle();
        start_run(8, 2, 13'h0);
        tick();
        tick();
        bus.phase_ce = 1'b1;
        bus.phase_inc = 1'b0;
        tick();
        bus.phase_ce = 1'b0;
        check_eq("pre_rst_busy", bus.phase_busy, 1);
        check_eq("pre_rst_pos", bus.phase_pos, 62);
        check_eq("pre_rst_sat", bus.saturated, 1);
        #2 rst = 1'b1;
        #1 reset_outputs("async_rst");
        tick();
        tick();
        rst = 1'b0;
        model_pos = 0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.drdy && n < 200);
        check_eq("rst_first_gap", n, 3);
        check_eq("rst_first_word", bus.data_out, 13'h0AAA);

        check_eq("data_hold", hold_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
